uart_tx_arbiter: RTL and testbench

//   Shares one uart_tx instance and its baud_pulse_gen among NUM_REQ client blocks.

---
 rtl/uart_tx_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter sharing one uart_tx (and its baud generator) among NUM_REQ clients, with packet lock.
// Optional LAUNCH watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN; without it tmo_err is tied low.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BAUD_HOLD  = 16,
  parameter int LAUNCH_TMO = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   cli_req,
  input  logic [8*NUM_REQ-1:0] cli_byte,
  input  logic [NUM_REQ-1:0]   cli_last,
  output logic [NUM_REQ-1:0]   cli_ack,
  output logic [2:0]           gnt_id,
  output logic                 gnt_vld,
  output logic                 baud_en,
  output logic                 tx_req,
  output logic [7:0]           tx_byte,
  input  logic                 tx_busy,
  output logic                 tmo_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = $clog2(BAUD_HOLD + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || BAUD_HOLD < 1 || LAUNCH_TMO < 1) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_SEND} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      own_q, own_d;
  logic               lock_q, lock_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tx_req_q, tx_req_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               gnt_vld_q, gnt_vld_d;
  logic               baud_q, baud_d;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IW-1:0]        win_off;
  logic [IW:0]          win_sum;
  logic [IW-1:0]        win_idx;
  logic                 own_req;
  logic [IW-1:0]        rr_next;
  logic                 do_grant;
  logic                 do_release;
  logic [IW-1:0]        g_idx;
  logic [7:0]           g_byte;
  logic                 g_last;

  // Rotate requests so rr_q lands at bit 0; the lowest set bit is the winner's offset.
  always_comb begin
    req_dbl = {cli_req, cli_req} >> rr_q;
    req_rot = req_dbl[NUM_REQ-1:0];
    win_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) win_off = IW'(k);
    end
    win_sum = {1'b0, rr_q} + {1'b0, win_off};
    win_idx = (win_sum >= (IW+1)'(NUM_REQ)) ? IW'(win_sum - (IW+1)'(NUM_REQ)) : win_sum[IW-1:0];
  end

  always_comb begin
    own_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (own_q == IW'(i)) own_req = cli_req[i];
    end
    rr_next = (own_q == IW'(NUM_REQ - 1)) ? '0 : own_q + IW'(1);
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(LAUNCH_TMO + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_q, tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    own_d      = own_q;
    lock_d     = lock_q;
    hold_d     = hold_q;
    ack_d      = '0;
    tx_req_d   = tx_req_q;
    tx_byte_d  = tx_byte_q;
    gnt_vld_d  = gnt_vld_q;
    baud_d     = baud_q;
    do_grant   = 1'b0;
    do_release = 1'b0;
    g_idx      = own_q;
    g_byte     = 8'h00;
    g_last     = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    tmo_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (|cli_req) begin
          do_grant = 1'b1;
          g_idx    = win_idx;
        end else if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
          if (hold_q == HW'(1)) baud_d = 1'b0;
        end
      end
      S_LAUNCH: begin
        if (tx_busy) begin
          tx_req_d = 1'b0;
          state_d  = S_SEND;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TW'(LAUNCH_TMO - 1)) begin
          tx_req_d   = 1'b0;
          tmo_d      = 1'b1;
          do_release = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      S_SEND: begin
        // A locked owner whose req has dropped is an aborted packet: fall through to release.
        if (!tx_busy) begin
          if (lock_q && own_req) do_grant   = 1'b1;
          else                   do_release = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < NUM_REQ; i++) begin
      if (g_idx == IW'(i)) begin
        g_byte = cli_byte[8*i +: 8];
        g_last = cli_last[i];
      end
    end

    if (do_grant) begin
      ack_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << g_idx;
      tx_byte_d = g_byte;
      tx_req_d  = 1'b1;
      own_d     = g_idx;
      gnt_vld_d = 1'b1;
      baud_d    = 1'b1;
      lock_d    = ~g_last;
      hold_d    = '0;
      state_d   = S_LAUNCH;
`ifdef UART_TX_ARB_TIMEOUT_EN
      tmo_cnt_d = '0;
`endif
    end

    if (do_release) begin
      rr_d      = rr_next;
      lock_d    = 1'b0;
      gnt_vld_d = 1'b0;
      hold_d    = HW'(BAUD_HOLD);
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      own_q     <= '0;
      lock_q    <= 1'b0;
      hold_q    <= '0;
      ack_q     <= '0;
      tx_req_q  <= 1'b0;
      tx_byte_q <= 8'h00;
      gnt_vld_q <= 1'b0;
      baud_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      own_q     <= own_d;
      lock_q    <= lock_d;
      hold_q    <= hold_d;
      ack_q     <= ack_d;
      tx_req_q  <= tx_req_d;
      tx_byte_q <= tx_byte_d;
      gnt_vld_q <= gnt_vld_d;
      baud_q    <= baud_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end
  assign tmo_err = tmo_q;
`else
  assign tmo_err = 1'b0;
`endif

  assign cli_ack = ack_q;
  assign gnt_id  = 3'(own_q);
  assign gnt_vld = gnt_vld_q;
  assign baud_en = baud_q;
  assign tx_req  = tx_req_q;
  assign tx_byte = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued client packets, packet-level round-robin model, uart_tx responder.
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int HOLD = 16;
  localparam int TMO  = 4096;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   cli_req, cli_last, cli_ack;
  logic [8*N-1:0] cli_byte;
  logic [2:0]     gnt_id;
  logic           gnt_vld, baud_en, tx_req, tx_busy, tmo_err;
  logic [7:0]     tx_byte;

  uart_tx_arbiter #(.NUM_REQ(N), .BAUD_HOLD(HOLD), .LAUNCH_TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cli_req(cli_req), .cli_byte(cli_byte), .cli_last(cli_last),
    .cli_ack(cli_ack), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .baud_en(baud_en), .tx_req(tx_req),
    .tx_byte(tx_byte), .tx_busy(tx_busy), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct { int c; logic [7:0] b; } exp_t;
  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] rb[N][64];
  bit         rl[N][64];
  int         chead[N], ctail[N];
  int         stg_len[N];
  logic [7:0] stg_b[N][8];
  bit         stg_l[N][8];
  int         mrr;
  bit         stuck;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic stage_clear();
    for (int c = 0; c < N; c++) stg_len[c] = 0;
  endtask

  task automatic stage_add(input int c, input logic [7:0] b, input bit l);
    stg_b[c][stg_len[c]] = b;
    stg_l[c][stg_len[c]] = l;
    stg_len[c]++;
  endtask

  // Hand staged bytes to the clients and predict the transmit order packet by packet.
  task automatic launch_burst();
    int  pos[N];
    int  c;
    bit  found, done;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < stg_len[i]; k++) begin
        rb[i][ctail[i] % 64] = stg_b[i][k];
        rl[i][ctail[i] % 64] = stg_l[i][k];
        ctail[i]++;
      end
      pos[i] = 0;
    end
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      c = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && pos[(mrr + k) % N] < stg_len[(mrr + k) % N]) begin
          found = 1'b1;
          c = (mrr + k) % N;
        end
      end
      if (found) begin
        done = 1'b0;
        while (!done && pos[c] < stg_len[c]) begin
          exp_q.push_back('{c: c, b: stg_b[c][pos[c]]});
          done = stg_l[c][pos[c]];
          pos[c]++;
        end
        mrr = (c + 1) % N;
      end
    end
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++) if (chead[i] != ctail[i]) return 1'b0;
    return exp_q.size() == 0;
  endfunction

  task automatic finish_burst(input bit measure);
    int n = 0;
    while (!(drained() && !gnt_vld) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("burst_done", n < 5000, 1);
    if (n < 5000 && measure) begin
      n = 0;
      while (baud_en && n < HOLD + 8) begin
        n++;
        @(negedge clk);
      end
      check("baud_hold", n, HOLD);
    end
  endtask

  task automatic client_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rst_n) chead[i] = ctail[i];
        else if (cli_ack[i] && chead[i] != ctail[i]) chead[i]++;
        if (chead[i] != ctail[i]) begin
          cli_req[i]         = 1'b1;
          cli_byte[8*i +: 8] = rb[i][chead[i] % 64];
          cli_last[i]        = rl[i][chead[i] % 64];
        end else begin
          cli_req[i]         = 1'b0;
          cli_byte[8*i +: 8] = 8'h00;
          cli_last[i]        = 1'b0;
        end
      end
    end
  endtask

  task automatic uart_loop();
    int dly = -1;
    int bcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_busy = 1'b0;
        dly = -1;
      end else if (tx_busy) begin
        if (bcnt == 0) tx_busy = 1'b0;
        else bcnt--;
      end else if (tx_req && !stuck) begin
        if (dly < 0) dly = int'($urandom_range(0, 2));
        if (dly == 0) begin
          tx_busy = 1'b1;
          bcnt = int'($urandom_range(1, 5));
          dly = -1;
        end else dly--;
      end
    end
  endtask

  task automatic monitor_loop();
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && tx_req && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_launch: byte %0h from client %0d with nothing expected", tx_byte, gnt_id);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", tx_byte, e.b);
          check("gnt_id", gnt_id, e.c);
          check("cli_ack", cli_ack, 32'(1) << e.c);
          check("gnt_vld", gnt_vld, 1);
          check("baud_on_grant", baud_en, 1);
        end
      end
      prev = tx_req;
    end
  endtask

  initial begin
    int n, lows, np, len;
    bit l;
    cli_req = '0; cli_byte = '0; cli_last = '0; tx_busy = 1'b0;
    stuck = 1'b0; mrr = 0;
    for (int i = 0; i < N; i++) begin chead[i] = 0; ctail[i] = 0; end
    fork
      client_loop();
      uart_loop();
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    check("rst_ack", cli_ack, 0);
    check("rst_gnt_vld", gnt_vld, 0);
    check("rst_gnt_id", gnt_id, 0);
    check("rst_baud", baud_en, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_tmo", tmo_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    stage_clear(); stage_add(0, 8'hA5, 1'b1); launch_burst(); finish_burst(1'b1);
    stage_clear(); for (int c = 0; c < N; c++) stage_add(c, 8'(8'h11 * (c + 1)), 1'b1);
    launch_burst(); finish_burst(1'b1);
    stage_clear(); stage_add(1, 8'h55, 1'b1); launch_burst(); finish_burst(1'b1);
    stage_clear(); for (int c = 0; c < N; c++) stage_add(c, 8'(8'h11 * (c + 1)), 1'b1);
    launch_burst(); finish_burst(1'b1);

    // Three-byte locked packet from client 1 racing a single byte from client 0.
    stage_clear();
    stage_add(1, 8'h01, 1'b0); stage_add(1, 8'h02, 1'b0); stage_add(1, 8'h03, 1'b1);
    stage_add(0, 8'h0F, 1'b1);
    launch_burst(); finish_burst(1'b1);

    // Client 2 abandons its packet after one byte.
    stage_clear(); stage_add(2, 8'h77, 1'b0); stage_add(3, 8'h88, 1'b1);
    launch_burst(); finish_burst(1'b1);

    // New request late in the hold window must not let baud_en drop.
    stage_clear(); stage_add(0, 8'hC3, 1'b1); launch_burst(); finish_burst(1'b0);
    repeat (HOLD - 3) @(negedge clk);
    stage_clear(); stage_add(2, 8'h3C, 1'b1); launch_burst();
    lows = 0;
    repeat (8) begin
      @(negedge clk);
      if (!baud_en) lows++;
    end
    check("baud_continuous", lows, 0);
    finish_burst(1'b1);

    for (int r = 0; r < 30; r++) begin
      stage_clear();
      for (int c = 0; c < N; c++) begin
        np = int'($urandom_range(0, 2));
        for (int p = 0; p < np; p++) begin
          len = int'($urandom_range(1, 3));
          for (int k = 0; k < len; k++) begin
            l = (k == len - 1) && !(p == np - 1 && $urandom_range(0, 3) == 0);
            stage_add(c, 8'($urandom), l);
          end
        end
      end
      if (stg_len[0] + stg_len[1] + stg_len[2] + stg_len[3] == 0) stage_add(r % N, 8'($urandom), 1'b1);
      launch_burst();
      finish_burst(1'b1);
    end

    // Reset while in LAUNCH (uart held off) and while in SEND.
    for (int mode = 0; mode < 2; mode++) begin
      stuck = (mode == 0);
      stage_clear(); stage_add(1, 8'(8'h5A + mode), 1'b1); launch_burst();
      n = 0;
      while (!((mode == 0) ? tx_req : tx_busy) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("rst_reach_state", n < 100, 1);
      if (mode == 1) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_tx_req", tx_req, 0);
      check("arst_ack", cli_ack, 0);
      check("arst_gnt_vld", gnt_vld, 0);
      check("arst_baud", baud_en, 0);
      @(negedge clk);
      stuck = 1'b0;
      rst_n = 1'b1;
      mrr = 0;
      check("arst_exp_consumed", exp_q.size(), 0);
      @(negedge clk);
    end
    stage_clear(); for (int c = 0; c < N; c++) stage_add(c, 8'(8'hA0 + c), 1'b1);
    launch_burst(); finish_burst(1'b1);

`ifdef UART_TX_ARB_TIMEOUT_EN
    stuck = 1'b1;
    stage_clear(); stage_add(3, 8'hE7, 1'b1); launch_burst();
    n = 0;
    while (!tmo_err && n < TMO + 50) begin
      @(negedge clk);
      n++;
    end
    check("tmo_pulse", tmo_err, 1);
    @(negedge clk);
    check("tmo_single", tmo_err, 0);
    check("tmo_gnt_vld", gnt_vld, 0);
    check("tmo_tx_req", tx_req, 0);
    stuck = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
